// File: rtl/reg_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
package reg_arb_pkg;
    localparam int unsigned DEF_DEPTH  = 2;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned REG_COUNT  = 32;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of the two writeback request channels and the register-file write port.
interface reg_write_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic                 a_valid;
    logic [REG_AW-1:0]    a_addr;
    logic [DATA_W-1:0]    a_data;
    logic                 a_ready;
    logic                 b_valid;
    logic [REG_AW-1:0]    b_addr;
    logic [DATA_W-1:0]    b_data;
    logic                 b_ready;
    logic                 write;
    logic [REG_AW-1:0]    inaddress;
    logic [DATA_W-1:0]    in_data;
    logic [REG_COUNT-1:0] pending;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, write, inaddress, in_data, pending
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, write, inaddress, in_data, pending
    );
endinterface

// File: rtl/wb_fifo.sv
// Per-requester writeback queue; exposes every slot's valid bit and address for hazard tracking.
module wb_fifo
    import reg_arb_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned ENTRY_W = DEF_DATA_W + REG_AW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push,
    input  logic [ENTRY_W-1:0]              push_entry,
    input  logic                            pop,
    output logic                            full,
    output logic                            empty,
    output logic [ENTRY_W-1:0]              head,
    output logic [DEPTH-1:0]                entry_vld,
    output logic [DEPTH-1:0][REG_AW-1:0]    entry_addr
);
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PW + 1;

    logic [PW-1:0]                  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic [DEPTH-1:0][ENTRY_W-1:0]  mem_q, mem_d;
    logic [DEPTH-1:0]               vld_q, vld_d;
    logic                           do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        vld_d    = vld_q;
        // Pop is applied before push; they never touch the same slot since
        // push is blocked when full and pop is blocked when empty.
        if (do_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PW'(1);
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_comb begin
        entry_vld = vld_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_addr[i] = mem_q[i][REG_AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
            vld_q    <= vld_d;
        end
    end
endmodule

// File: rtl/reg_write_arbiter.sv
// Merges ALU and load writebacks into one register-file write port with round-robin
// arbitration, x0 suppression and a per-register pending-write vector.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 A_VALID,
    input  logic [REG_AW-1:0]    A_ADDR,
    input  logic [DATA_W-1:0]    A_DATA,
    output logic                 A_READY,
    input  logic                 B_VALID,
    input  logic [REG_AW-1:0]    B_ADDR,
    input  logic [DATA_W-1:0]    B_DATA,
    output logic                 B_READY,
    output logic                 WRITE,
    output logic [REG_AW-1:0]    INADDRESS,
    output logic [DATA_W-1:0]    IN,
    output logic [REG_COUNT-1:0] PENDING
);
    localparam int unsigned ENTRY_W = DATA_W + REG_AW;

    logic                         a_full, a_empty, b_full, b_empty;
    logic [ENTRY_W-1:0]           a_head, b_head, pop_entry;
    logic [DEPTH-1:0]             a_vld, b_vld;
    logic [DEPTH-1:0][REG_AW-1:0] a_addrs, b_addrs;
    logic                         grant_a, grant_b;

    req_id_e                      rr_q, rr_d;
    logic                         write_q, write_d;
    logic [REG_AW-1:0]            addr_q, addr_d;
    logic [DATA_W-1:0]            data_q, data_d;

    assign A_READY = !a_full && !RESET;
    assign B_READY = !b_full && !RESET;

    wb_fifo #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_fifo_a (
        .clk(CLK), .rst(RESET),
        .push(A_VALID && A_READY), .push_entry({A_DATA, A_ADDR}),
        .pop(grant_a), .full(a_full), .empty(a_empty), .head(a_head),
        .entry_vld(a_vld), .entry_addr(a_addrs)
    );

    wb_fifo #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W)) u_fifo_b (
        .clk(CLK), .rst(RESET),
        .push(B_VALID && B_READY), .push_entry({B_DATA, B_ADDR}),
        .pop(grant_b), .full(b_full), .empty(b_empty), .head(b_head),
        .entry_vld(b_vld), .entry_addr(b_addrs)
    );

    always_comb begin
        grant_a   = !a_empty && (b_empty || rr_q == REQ_A);
        grant_b   = !b_empty && !grant_a;
        pop_entry = grant_a ? a_head : b_head;
        rr_d      = rr_q;
        write_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        if (grant_a) begin
            rr_d = REQ_B;
        end else if (grant_b) begin
            rr_d = REQ_A;
        end
        // x0 entries are consumed silently; the output registers keep the previous write.
        if ((grant_a || grant_b) && pop_entry[REG_AW-1:0] != '0) begin
            write_d = 1'b1;
            addr_d  = pop_entry[REG_AW-1:0];
            data_d  = pop_entry[ENTRY_W-1:REG_AW];
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rr_q    <= REQ_A;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            rr_q    <= rr_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        PENDING = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (a_vld[i]) PENDING[a_addrs[i]] = 1'b1;
            if (b_vld[i]) PENDING[b_addrs[i]] = 1'b1;
        end
        if (write_q) PENDING[addr_q] = 1'b1;
        PENDING[0] = 1'b0;
    end

    assign WRITE     = write_q;
    assign INADDRESS = addr_q;
    assign IN        = data_q;
endmodule
